yp_fifo_rd_packer: RTL and testbench

- Downstream consumer stage of the team's synchronous FIFO.
- Pops DATA_WIDTH words from the FIFO read port (pop-to-data latency of 1 cycle) and packs PACK_RATIO consecutive words into one wide beat.
- Presents each beat on a valid/ready stream interface.
- A flush input emits a partial beat with a lane-keep mask and end marker.

---
 rtl/yp_fifo_pkg.sv | 18 +
 rtl/yp_fifo_out_slot.sv | 57 +++++
 rtl/yp_fifo_rd_packer.sv | 133 +++++++++++++
 tb/tb_yp_fifo_rd_packer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yp_fifo_pkg.sv
// Shared constants and helpers for the FIFO stream stages.
package yp_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PACK_RATIO = 4;

  // Low lane_cnt bits set; callers cast the result down to their lane count.
  function automatic logic [63:0] keep_mask(input int unsigned lane_cnt);
    logic [63:0] m;
    if (lane_cnt >= 64) begin
      m = '1;
    end else begin
      m = (64'(1) << lane_cnt) - 64'(1);
    end
    return m;
  endfunction

endpackage

// File: rtl/yp_fifo_out_slot.sv
// Valid/ready output holding register: loads a new entry, holds it while stalled, clears on transfer.
module yp_fifo_out_slot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [KEEP_W-1:0] i_keep,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_free,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [KEEP_W-1:0] o_keep,
  output logic              o_last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              last_q, last_d;

  always_comb begin
    o_free  = !valid_q || i_ready;
    valid_d = i_load || (valid_q && !i_ready);
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (i_load) begin
      data_d = i_data;
      keep_d = i_keep;
      last_d = i_last;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_keep  = keep_q;
  assign o_last  = last_q;

endmodule

// File: rtl/yp_fifo_rd_packer.sv
// Pops FIFO words (1-cycle read latency) and packs PACK_RATIO of them into one valid/ready beat;
// a flush closes a partial beat with a lane-keep mask and o_last.
module yp_fifo_rd_packer
  import yp_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PACK_RATIO = DEF_PACK_RATIO
) (
  input  logic                             i_clk,
  input  logic                             i_rstn,
  input  logic                             i_fifo_empty,
  input  logic [DATA_WIDTH-1:0]            i_fifo_data,
  output logic                             o_fifo_rd_en,
  input  logic                             i_flush,
  output logic                             o_flush_busy,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] o_data,
  output logic [PACK_RATIO-1:0]            o_keep,
  output logic                             o_last
);

  localparam int unsigned CW = $clog2(PACK_RATIO + 1);
  localparam int unsigned BW = DATA_WIDTH * PACK_RATIO;
  localparam logic [CW-1:0] LAST_LANE = CW'(PACK_RATIO - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(PACK_RATIO);

  logic [CW-1:0]         lane_cnt_q, lane_cnt_d;
  logic [BW-1:0]         pack_q, pack_d, pack_wr;
  logic                  pending_q, pending_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  flush_clear;
  logic                  can_take, rd_en, out_free;
  logic                  slot_load, slot_last;
  logic [PACK_RATIO-1:0] slot_keep;

  always_comb begin
    pack_wr = pack_q;
    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
      if (pending_q && lane_cnt_q == CW'(i)) begin
        pack_wr[i*DATA_WIDTH +: DATA_WIDTH] = i_fifo_data;
      end
    end

    // Only pop when the word arriving next cycle is guaranteed a lane.
    if (pending_q) begin
      can_take = (lane_cnt_q == LAST_LANE) ? out_free : 1'b1;
    end else begin
      can_take = (lane_cnt_q == FULL_CNT) ? out_free : 1'b1;
    end
    rd_en     = i_rstn && !i_fifo_empty && !flush_pend_q && can_take;
    pending_d = rd_en;

    lane_cnt_d  = lane_cnt_q;
    pack_d      = pack_q;
    slot_load   = 1'b0;
    slot_keep   = '1;
    slot_last   = flush_pend_q;
    flush_clear = 1'b0;

    if (pending_q) begin
      if (lane_cnt_q == LAST_LANE) begin
        if (out_free) begin
          slot_load  = 1'b1;
          pack_d     = '0;
          lane_cnt_d = '0;
        end else begin
          pack_d     = pack_wr;
          lane_cnt_d = FULL_CNT;
        end
      end else begin
        pack_d     = pack_wr;
        lane_cnt_d = lane_cnt_q + CW'(1);
      end
    end else if (lane_cnt_q == FULL_CNT) begin
      if (out_free) begin
        slot_load  = 1'b1;
        pack_d     = '0;
        lane_cnt_d = '0;
      end
    end else if (flush_pend_q) begin
      if (lane_cnt_q == '0) begin
        flush_clear = 1'b1;
      end else if (out_free) begin
        slot_load  = 1'b1;
        slot_keep  = PACK_RATIO'(keep_mask(32'(lane_cnt_q)));
        pack_d     = '0;
        lane_cnt_d = '0;
      end
    end

    if (slot_load && flush_pend_q) begin
      flush_clear = 1'b1;
    end
    flush_pend_d = flush_clear ? 1'b0 : (flush_pend_q || i_flush);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      lane_cnt_q   <= '0;
      pack_q       <= '0;
      pending_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      lane_cnt_q   <= lane_cnt_d;
      pack_q       <= pack_d;
      pending_q    <= pending_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  yp_fifo_out_slot #(
    .DATA_W (BW),
    .KEEP_W (PACK_RATIO)
  ) u_out_slot (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_load  (slot_load),
    .i_data  (pack_wr),
    .i_keep  (slot_keep),
    .i_last  (slot_last),
    .i_ready (i_ready),
    .o_free  (out_free),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_keep  (o_keep),
    .o_last  (o_last)
  );

  assign o_fifo_rd_en = rd_en;
  assign o_flush_busy = flush_pend_q;

endmodule

// File: tb/tb_yp_fifo_rd_packer.sv
// Bench for yp_fifo_rd_packer: directed scenarios plus a randomized run against a word-stream model.
module tb_yp_fifo_rd_packer;

  localparam int unsigned DW = 8;
  localparam int unsigned PR = 4;
  localparam int unsigned BW = DW * PR;

  typedef struct {
    logic [BW-1:0] data;
    logic [PR-1:0] keep;
    logic          last;
  } beat_t;

  logic          i_clk;
  logic          i_rstn;
  logic          i_fifo_empty;
  logic [DW-1:0] i_fifo_data;
  logic          o_fifo_rd_en;
  logic          i_flush;
  logic          o_flush_busy;
  logic          o_valid;
  logic          i_ready;
  logic [BW-1:0] o_data;
  logic [PR-1:0] o_keep;
  logic          o_last;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pop_total = 0;
  logic [DW-1:0] fifo_q[$];
  beat_t got_q[$];

  yp_fifo_rd_packer #(
    .DATA_WIDTH (DW),
    .PACK_RATIO (PR)
  ) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_rd_en (o_fifo_rd_en),
    .i_flush      (i_flush),
    .o_flush_busy (o_flush_busy),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_keep       (o_keep),
    .o_last       (o_last)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // FIFO model: popped word shows up one cycle later, otherwise junk on the data bus.
  always @(posedge i_clk) begin
    if (o_fifo_rd_en) begin
      if (fifo_q.size() == 0) begin
        errors++;
        $display("FAIL pop_on_empty: rd_en=1 with FIFO empty, expected rd_en=0");
        i_fifo_data <= '0;
      end else begin
        i_fifo_data <= fifo_q.pop_front();
      end
      pop_total++;
    end else begin
      i_fifo_data <= DW'($urandom);
    end
    i_fifo_empty <= (fifo_q.size() == 0);
  end

  always @(posedge i_clk) begin
    if (i_rstn && o_valid && i_ready) begin
      got_q.push_back('{o_data, o_keep, o_last});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    i_fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rstn = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    fifo_q.delete();
    i_fifo_empty = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    got_q.delete();
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_ready = 1'b1;
    i_flush = 1'b0;
    #1 i_rstn = 1'b0;
    push_word(8'h5A);
    repeat (2) @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", o_valid); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_data got %h expected 0", o_data); end
    checks++; if (o_keep !== '0) begin errors++; $display("FAIL reset_keep got %h expected 0", o_keep); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b expected 0", o_last); end
    checks++; if (o_flush_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", o_flush_busy); end
    checks++; if (o_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b expected 0", o_fifo_rd_en); end
    i_rstn = 1'b1;
    #1;
    checks++; if (o_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL release_rd_en got %b expected 1", o_fifo_rd_en); end
  endtask

  task automatic test_stream();
    logic [11:0] rd_seen;
    int unsigned p0;
    logic [BW-1:0] exp_d [2];
    exp_d[0] = 32'h04030201;
    exp_d[1] = 32'h08070605;
    do_reset();
    i_ready = 1'b1;
    p0 = pop_total;
    for (int unsigned i = 1; i <= 8; i++) push_word(DW'(i));
    rd_seen = '0;
    for (int unsigned c = 0; c < 12; c++) begin
      #1 rd_seen[c] = o_fifo_rd_en;
      @(negedge i_clk);
    end
    repeat (4) @(negedge i_clk);
    checks++; if (rd_seen !== 12'h0FF) begin errors++; $display("FAIL stream_rd_pattern got %h expected 0ff", rd_seen); end
    checks++; if (pop_total - p0 != 8) begin errors++; $display("FAIL stream_pops got %0d expected 8", pop_total - p0); end
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL stream_beats got %0d expected 2", got_q.size()); end
    for (int unsigned b = 0; b < 2; b++) begin
      if (b < got_q.size()) begin
        checks++;
        if (got_q[b].data !== exp_d[b] || got_q[b].keep !== 4'hF || got_q[b].last !== 1'b0) begin
          errors++;
          $display("FAIL stream_beat%0d got %h/%h/%b expected %h/f/0", b, got_q[b].data, got_q[b].keep, got_q[b].last, exp_d[b]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned p0;
    logic [BW-1:0] exp_d [3];
    exp_d[0] = 32'h14131211;
    exp_d[1] = 32'h18171615;
    exp_d[2] = 32'h1C1B1A19;
    do_reset();
    p0 = pop_total;
    for (int unsigned i = 0; i < 12; i++) push_word(8'h11 + DW'(i));
    repeat (16) @(negedge i_clk);
    checks++; if (pop_total - p0 != 8) begin errors++; $display("FAIL bp_pops got %0d expected 8", pop_total - p0); end
    checks++; if (o_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en got %b expected 0", o_fifo_rd_en); end
    for (int unsigned c = 0; c < 4; c++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp_d[0] || o_keep !== 4'hF || o_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got v=%b %h/%h/%b expected v=1 %h/f/0", o_valid, o_data, o_keep, o_last, exp_d[0]);
      end
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    repeat (20) @(negedge i_clk);
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL bp_beats got %0d expected 3", got_q.size()); end
    for (int unsigned b = 0; b < 3; b++) begin
      if (b < got_q.size()) begin
        checks++;
        if (got_q[b].data !== exp_d[b] || got_q[b].keep !== 4'hF || got_q[b].last !== 1'b0) begin
          errors++;
          $display("FAIL bp_beat%0d got %h/%h/%b expected %h/f/0", b, got_q[b].data, got_q[b].keep, got_q[b].last, exp_d[b]);
        end
      end
    end
  endtask

  task automatic test_flush_partial();
    do_reset();
    i_ready = 1'b1;
    push_word(8'hA1);
    push_word(8'hA2);
    push_word(8'hA3);
    repeat (2) @(negedge i_clk);
    checks++; if (o_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL flush_third_pop got %b expected 1", o_fifo_rd_en); end
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    push_word(8'hA4);
    #1;
    checks++; if (o_flush_busy !== 1'b1) begin errors++; $display("FAIL flush_busy_set got %b expected 1", o_flush_busy); end
    checks++; if (o_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL flush_blocks_pop got %b expected 0", o_fifo_rd_en); end
    repeat (6) @(negedge i_clk);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL flush_beats got %0d expected 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0].data !== 32'h00A3A2A1 || got_q[0].keep !== 4'h7 || got_q[0].last !== 1'b1) begin
        errors++;
        $display("FAIL flush_beat got %h/%h/%b expected 00a3a2a1/7/1", got_q[0].data, got_q[0].keep, got_q[0].last);
      end
    end
    checks++; if (o_flush_busy !== 1'b0) begin errors++; $display("FAIL flush_busy_clear got %b expected 0", o_flush_busy); end
  endtask

  task automatic test_flush_empty();
    int unsigned n;
    do_reset();
    i_ready = 1'b1;
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    n = 0;
    for (int unsigned c = 0; c < 6; c++) begin
      if (o_flush_busy === 1'b1) n++;
      @(negedge i_clk);
    end
    checks++; if (n != 1) begin errors++; $display("FAIL flush_empty_busy_cycles got %0d expected 1", n); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL flush_empty_beats got %0d expected 0", got_q.size()); end
  endtask

  task automatic test_reset_midop();
    bit found;
    int unsigned prev;
    do_reset();
    for (int unsigned i = 0; i < 6; i++) push_word(8'hE1 + DW'(i));
    found = 1'b0;
    prev = pop_total;
    for (int unsigned c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1 && pop_total != prev) begin
        found = 1'b1;
        break;
      end
      prev = pop_total;
    end
    checks++; if (!found) begin errors++; $display("FAIL midop_setup got found=0 expected found=1"); end
    i_rstn = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_keep !== '0 || o_last !== 1'b0 || o_fifo_rd_en !== 1'b0 || o_flush_busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset got v=%b d=%h k=%h l=%b rd=%b busy=%b expected all 0", o_valid, o_data, o_keep, o_last, o_fifo_rd_en, o_flush_busy);
    end
    @(negedge i_clk);
    fifo_q.delete();
    i_fifo_empty = 1'b1;
    @(negedge i_clk);
    i_rstn = 1'b1;
    i_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) push_word(8'h31 + DW'(i));
    repeat (10) @(negedge i_clk);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL midop_beats got %0d expected 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0].data !== 32'h34333231 || got_q[0].keep !== 4'hF || got_q[0].last !== 1'b0) begin
        errors++;
        $display("FAIL midop_beat got %h/%h/%b expected 34333231/f/0", got_q[0].data, got_q[0].keep, got_q[0].last);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] w;
    logic [DW-1:0] lane_v;
    beat_t b;
    bit stall;
    logic [BW-1:0] hold_d;
    logic [PR-1:0] hold_k;
    logic hold_l;
    int unsigned guard;
    int unsigned n;
    do_reset();
    stall = 1'b0;
    hold_d = '0;
    hold_k = '0;
    hold_l = 1'b0;
    for (int unsigned c = 0; c < 800; c++) begin
      if (stall) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== hold_d || o_keep !== hold_k || o_last !== hold_l) begin
          errors++;
          $display("FAIL rand_hold cyc%0d got v=%b %h/%h/%b expected v=1 %h/%h/%b", c, o_valid, o_data, o_keep, o_last, hold_d, hold_k, hold_l);
        end
      end
      i_flush = ($urandom_range(0, 39) == 0);
      i_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 3);
        for (int unsigned k = 0; k < n; k++) begin
          w = DW'($urandom);
          push_word(w);
          exp_q.push_back(w);
        end
      end
      stall  = o_valid && !i_ready;
      hold_d = o_data;
      hold_k = o_keep;
      hold_l = o_last;
      @(negedge i_clk);
    end
    i_flush = 1'b0;
    i_ready = 1'b1;
    guard = 0;
    while (fifo_q.size() != 0 && guard < 400) begin
      @(negedge i_clk);
      guard++;
    end
    repeat (3) @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    guard = 0;
    while ((o_flush_busy === 1'b1 || o_valid === 1'b1) && guard < 50) begin
      @(negedge i_clk);
      guard++;
    end
    checks++;
    if (o_flush_busy !== 1'b0 || o_valid !== 1'b0 || fifo_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain got busy=%b valid=%b fifo=%0d expected 0/0/0", o_flush_busy, o_valid, fifo_q.size());
    end
    repeat (2) @(negedge i_clk);
    while (got_q.size() != 0) begin
      b = got_q.pop_front();
      checks++;
      if (!(b.keep inside {4'h1, 4'h3, 4'h7, 4'hF}) || (b.last !== 1'b1 && b.keep !== 4'hF)) begin
        errors++;
        $display("FAIL rand_keep got keep=%h last=%b expected contiguous mask, f unless last", b.keep, b.last);
      end
      for (int unsigned l = 0; l < PR; l++) begin
        lane_v = b.data[l*DW +: DW];
        checks++;
        if (b.keep[l]) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rand_extra_word got %h expected no more words", lane_v);
          end else begin
            w = exp_q.pop_front();
            if (lane_v !== w) begin
              errors++;
              $display("FAIL rand_word lane%0d got %h expected %h", l, lane_v, w);
            end
          end
        end else if (lane_v !== '0) begin
          errors++;
          $display("FAIL rand_unkept_lane%0d got %h expected 00", l, lane_v);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_words_lost got %0d left expected 0", exp_q.size());
    end
  endtask

  initial begin
    i_rstn = 1'b1;
    i_fifo_empty = 1'b1;
    i_flush = 1'b0;
    i_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_partial();
    test_flush_empty();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
